fetch_unit: RTL

//  RV32 instruction-fetch stage: owns the PC, issues word requests to instruction memory and holds
//  the fetched instruction for decode. instr_o[6:0]/[14:12] feed the main decoder's op/funct3.

---
 rtl/rv_core_pkg.sv | 15 +
 rtl/fetch_skid_buf.sv | 43 ++++
 rtl/fetch_unit.sv | 155 +++++++++++++++
 3 files changed

// File: rtl/rv_core_pkg.sv
// Shared fetch-stage types for the RV32 core: fetch FSM encoding and the reset NOP.
package rv_core_pkg;

  typedef enum logic [2:0] {
    S_REQ   = 3'd0,
    S_WAIT  = 3'd1,
    S_SKID  = 3'd2,
    S_DRAIN = 3'd3,
    S_TRAP  = 3'd4
  } fetch_state_e;

  // addi x0, x0, 0
  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

endpackage

// File: rtl/fetch_skid_buf.sv
// One-entry instruction+PC holding register that catches a response arriving
// while decode is stalled. Clear has priority over load, load over unload.
module fetch_skid_buf #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            load_i,
  input  logic            unload_i,
  input  logic            clear_i,
  input  logic [31:0]     instr_i,
  input  logic [XLEN-1:0] pc_i,
  output logic            valid_o,
  output logic [31:0]     instr_o,
  output logic [XLEN-1:0] pc_o
);
  import rv_core_pkg::*;

  logic            valid_q;
  logic [31:0]     instr_q;
  logic [XLEN-1:0] pc_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      valid_q <= 1'b0;
      instr_q <= NOP_INSTR;
      pc_q    <= '0;
    end else begin
      if (clear_i)       valid_q <= 1'b0;
      else if (load_i)   valid_q <= 1'b1;
      else if (unload_i) valid_q <= 1'b0;
      if (load_i && !clear_i) begin
        instr_q <= instr_i;
        pc_q    <= pc_i;
      end
    end
  end

  assign valid_o = valid_q;
  assign instr_o = instr_q;
  assign pc_o    = pc_q;

endmodule

// File: rtl/fetch_unit.sv
// RV32 fetch stage: owns the PC, keeps one imem request in flight, squashes wrong-path fetches.
// Build option FETCH_MISALIGN_TRAP_EN: misaligned redirect targets park the stage in S_TRAP.
module fetch_unit #(
  parameter int              XLEN     = 32,
  parameter logic [XLEN-1:0] RESET_PC = '0
) (
  input  logic            clk,
  input  logic            reset,
  output logic            imem_req,
  output logic [XLEN-1:0] imem_addr,
  input  logic            imem_valid,
  input  logic [31:0]     imem_rdata,
  input  logic            redirect,
  input  logic [XLEN-1:0] redirect_target,
  input  logic            id_ready,
  output logic            instr_valid_o,
  output logic [31:0]     instr_o,
  output logic [XLEN-1:0] pc_o,
  output logic [XLEN-1:0] pc_plus4_o
`ifdef FETCH_MISALIGN_TRAP_EN
  ,
  output logic            fetch_misalign_o
`endif
);
  import rv_core_pkg::*;

  fetch_state_e    state_q;
  logic [XLEN-1:0] fetch_pc_q;
  logic [XLEN-1:0] pc_q;
  logic [31:0]     instr_q;
  logic            instr_valid_q;
  logic            outstanding_q;

  logic            out_free;
  logic            req;
  logic [XLEN-1:0] req_addr;
  logic [XLEN-1:0] tgt_pc;
  logic            still_out;
  logic            skid_load;
  logic            skid_unload;
  logic            skid_valid;
  logic [31:0]     skid_instr;
  logic [XLEN-1:0] skid_pc;

`ifdef FETCH_MISALIGN_TRAP_EN
  logic misalign_q;
  logic tgt_misaligned;
  assign tgt_misaligned   = |redirect_target[1:0];
  assign tgt_pc           = redirect_target;
  assign fetch_misalign_o = misalign_q;
`else
  assign tgt_pc = redirect_target & ~XLEN'(3);
`endif

  assign out_free  = !instr_valid_q || id_ready;
  // A response landing in a redirect cycle is dropped and no longer counts as in flight.
  assign still_out = outstanding_q && !imem_valid;

  always_comb begin
    req      = 1'b0;
    req_addr = fetch_pc_q;
    case (state_q)
      S_REQ:   req = out_free;
      S_WAIT: begin
        // fetch_pc_q still names the in-flight word; the follow-on request is the next one.
        req      = imem_valid && out_free;
        req_addr = fetch_pc_q + XLEN'(4);
      end
      S_SKID:  req = skid_valid && id_ready;
      default: req = 1'b0;
    endcase
    if (reset || redirect) req = 1'b0;
  end

  assign imem_req  = req;
  assign imem_addr = req_addr;

  assign skid_load   = !reset && !redirect && (state_q == S_WAIT) && imem_valid && !out_free;
  assign skid_unload = !reset && !redirect && (state_q == S_SKID) && skid_valid && id_ready;

  fetch_skid_buf #(.XLEN(XLEN)) u_skid (
    .clk      (clk),
    .reset    (reset),
    .load_i   (skid_load),
    .unload_i (skid_unload),
    .clear_i  (redirect),
    .instr_i  (imem_rdata),
    .pc_i     (fetch_pc_q),
    .valid_o  (skid_valid),
    .instr_o  (skid_instr),
    .pc_o     (skid_pc)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= S_REQ;
      fetch_pc_q    <= RESET_PC;
      pc_q          <= RESET_PC;
      instr_q       <= NOP_INSTR;
      instr_valid_q <= 1'b0;
      outstanding_q <= 1'b0;
`ifdef FETCH_MISALIGN_TRAP_EN
      misalign_q    <= 1'b0;
`endif
    end else if (redirect) begin
      fetch_pc_q    <= tgt_pc;
      instr_valid_q <= 1'b0;
      outstanding_q <= still_out;
      state_q       <= still_out ? S_DRAIN : S_REQ;
`ifdef FETCH_MISALIGN_TRAP_EN
      misalign_q    <= tgt_misaligned;
      if (tgt_misaligned) begin
        state_q <= S_TRAP;
        pc_q    <= tgt_pc;
      end
`endif
    end else begin
      if (req)             outstanding_q <= 1'b1;
      else if (imem_valid) outstanding_q <= 1'b0;
      if (instr_valid_q && id_ready) instr_valid_q <= 1'b0;

      case (state_q)
        S_REQ: if (req) state_q <= S_WAIT;
        S_WAIT: begin
          if (imem_valid) begin
            fetch_pc_q <= fetch_pc_q + XLEN'(4);
            if (out_free) begin
              instr_valid_q <= 1'b1;
              instr_q       <= imem_rdata;
              pc_q          <= fetch_pc_q;
            end else begin
              state_q <= S_SKID;
            end
          end
        end
        S_SKID: begin
          if (skid_unload) begin
            instr_valid_q <= 1'b1;
            instr_q       <= skid_instr;
            pc_q          <= skid_pc;
            state_q       <= S_WAIT;
          end
        end
        S_DRAIN: if (imem_valid) state_q <= S_REQ;
        default: ;
      endcase
    end
  end

  assign instr_valid_o = instr_valid_q;
  assign instr_o       = instr_q;
  assign pc_o          = pc_q;
  assign pc_plus4_o    = pc_q + XLEN'(4);

endmodule
